jt51_wrseq: RTL and testbench

- Upstream write sequencer for jt51.
- Accepts register/value pairs from a host or sound-driver CPU into a FIFO.
- Replays each pair on the jt51 bus as an address write (a0=0) followed by a data write (a0=1).
- Honours the jt51 busy flag (dout[7]) and the cen_p1 sampling cadence, so the host never polls the chip.

---
 rtl/jt51_wrseq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_jt51_wrseq.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_wrseq.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_wrseq
//  Description : Write sequencer in front of a jt51. Queues register/value
//                pairs in a small FIFO and replays each one on the jt51 bus
//                as an address write (a0=0) followed by a data write (a0=1),
//                aligned to the cen_p1 cadence and honouring the busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_wrseq #(
    parameter int DW      = 4,
    parameter int BUSY_TO = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          push,
    input  logic [7:0]    reg_addr,
    input  logic [7:0]    reg_data,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [DW:0]   level,
    output logic          ovf,
    output logic          idle,
    output logic          jt_cs_n,
    output logic          jt_wr_n,
    output logic          jt_a0,
    output logic [7:0]    jt_din,
    input  logic [7:0]    jt_dout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int           c_depth    = 2 ** DW;
    localparam logic [DW:0]  c_full_lvl = (DW + 1)'(c_depth);
    // Tick counter only needs to reach BUSY_TO-1 before the timeout fires.
    localparam int           c_tw       = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);

    localparam logic [2:0] c_st_idle = 3'd0;  // waiting for a queued pair
    localparam logic [2:0] c_st_awr  = 3'd1;  // address strobe low
    localparam logic [2:0] c_st_agap = 3'd2;  // strobes high between writes
    localparam logic [2:0] c_st_dwr  = 3'd3;  // data strobe low
    localparam logic [2:0] c_st_bset = 3'd4;  // waiting for busy to rise
    localparam logic [2:0] c_st_bclr = 3'd5;  // waiting for busy to fall

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [15:0]     r_mem [c_depth];
    logic [DW-1:0]   r_wr_ptr;
    logic [DW-1:0]   r_rd_ptr;
    logic [DW:0]     r_level;
    logic            r_ovf;
    logic            r_idle;

    logic [2:0]      r_state;
    logic [7:0]      r_h_val;      // data byte of the pair in flight
    logic [c_tw-1:0] r_ticks;      // cen ticks spent waiting for busy

    logic            r_cs_n;
    logic            r_wr_n;
    logic            r_a0;
    logic [7:0]      r_din;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_busy;
    logic [15:0]     w_head;
    logic [DW:0]     w_level_nxt;
    logic [2:0]      w_state_nxt;
    logic            w_unused;

    assign w_full    = (r_level == c_full_lvl);
    assign w_empty   = (r_level == '0);
    // A push while full is dropped even if a pop happens this same cycle,
    // because the full decision is taken from the registered level.
    assign w_push_ok = push && !w_full;
    assign w_pop     = (r_state == c_st_idle) && !w_empty;
    assign w_busy    = jt_dout[7];
    assign w_head    = r_mem[r_rd_ptr];
    // Only the busy bit of the status byte is of interest here.
    assign w_unused  = &{1'b0, jt_dout[6:0]};

    // Next FIFO occupancy; push and pop together leave it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok && !w_pop) begin
            w_level_nxt = r_level + (DW + 1)'(1);
        end else if (!w_push_ok && w_pop) begin
            w_level_nxt = r_level - (DW + 1)'(1);
        end
    end

    // Next sequencer state; only the strobe and busy-timeout steps wait on cen.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_state_nxt = c_st_awr;
                end
            end
            c_st_awr: begin
                if (cen) begin
                    w_state_nxt = c_st_agap;
                end
            end
            c_st_agap: begin
                if (cen) begin
                    w_state_nxt = c_st_dwr;
                end
            end
            c_st_dwr: begin
                if (cen) begin
                    w_state_nxt = c_st_bset;
                end
            end
            c_st_bset: begin
                if (w_busy) begin
                    w_state_nxt = c_st_bclr;
                end else if (cen && (r_ticks == c_tw'(BUSY_TO - 1))) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_bclr: begin
                if (!w_busy) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------

    // Pair storage; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {reg_addr, reg_data};
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DW'(1);
            end
            r_level <= w_level_nxt;
            // A dropped push outranks a clear arriving in the same cycle.
            if (push && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------------

    // State register plus registered bus outputs, loaded with the values the
    // next state needs so the jt51 pins never see a combinational glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_h_val <= 8'h00;
            r_ticks <= '0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_din   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        // Address byte goes straight to the bus; keep the data.
                        r_din   <= w_head[15:8];
                        r_h_val <= w_head[7:0];
                        r_a0    <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                    end
                end
                c_st_awr: begin
                    if (cen) begin
                        r_cs_n <= 1'b1;
                        r_wr_n <= 1'b1;
                    end
                end
                c_st_agap: begin
                    if (cen) begin
                        // a0 and din only change while the strobes are high.
                        r_a0   <= 1'b1;
                        r_din  <= r_h_val;
                        r_cs_n <= 1'b0;
                        r_wr_n <= 1'b0;
                    end
                end
                c_st_dwr: begin
                    if (cen) begin
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_ticks <= '0;
                    end
                end
                c_st_bset: begin
                    if (!w_busy && cen) begin
                        r_ticks <= r_ticks + c_tw'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered idle indication: nothing queued and nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= (w_level_nxt == '0) && (w_state_nxt == c_st_idle);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign full    = w_full;
    assign empty   = w_empty;
    assign level   = r_level;
    assign ovf     = r_ovf;
    assign idle    = r_idle;
    assign jt_cs_n = r_cs_n;
    assign jt_wr_n = r_wr_n;
    assign jt_a0   = r_a0;
    assign jt_din  = r_din;

endmodule
`default_nettype wire

// File: tb/tb_jt51_wrseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt51_wrseq
//  Description : Self-checking bench for jt51_wrseq. A queue-based model of
//                the pair sequencing predicts every output each cycle; a few
//                directed scenarios pin exact cycle positions and contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt51_wrseq;

    localparam int DW      = 4;
    localparam int BUSY_TO = 8;
    localparam int DEPTH   = 16;

    // Pair progress phases used by the model
    localparam int P_IDLE = 0;
    localparam int P_ADDR = 1;
    localparam int P_GAP  = 2;
    localparam int P_DATA = 3;
    localparam int P_BSET = 4;
    localparam int P_BCLR = 5;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cen      = 1'b0;
    logic          push     = 1'b0;
    logic [7:0]    reg_addr = 8'h00;
    logic [7:0]    reg_data = 8'h00;
    logic          clr_ovf  = 1'b0;
    logic          full;
    logic          empty;
    logic [DW:0]   level;
    logic          ovf;
    logic          idle;
    logic          jt_cs_n;
    logic          jt_wr_n;
    logic          jt_a0;
    logic [7:0]    jt_din;
    logic [7:0]    jt_dout;

    int n_err    = 0;
    int n_checks = 0;

    // Stimulus knobs
    int cen_mode  = 0;     // 0: always 1, 1: every 2nd clk, 2: random
    bit cen_ph    = 1'b0;
    int busy_len  = 0;     // busy length after each data write
    bit hold_busy = 1'b0;
    int busy_cnt  = 0;

    // Model state
    logic [15:0] mq[$];
    int          phase;
    int          m_ticks;
    logic [7:0]  m_din;
    logic [7:0]  m_hval;
    logic        m_a0;
    logic        m_ovf;

    // Bus write log
    logic [15:0] wlog[$];
    logic [7:0]  last_addr = 8'h00;
    int          win_cen   = 0;
    bit          win_open  = 1'b0;

    jt51_wrseq #(.DW(DW), .BUSY_TO(BUSY_TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .push     (push),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .idle     (idle),
        .jt_cs_n  (jt_cs_n),
        .jt_wr_n  (jt_wr_n),
        .jt_a0    (jt_a0),
        .jt_din   (jt_din),
        .jt_dout  (jt_dout)
    );

    always #5 clk = ~clk;

    // jt51 busy emulation: busy rises after a completed data write
    always @(posedge clk) begin
        if (!jt_cs_n && !jt_wr_n && jt_a0 && cen) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign jt_dout = {(busy_cnt != 0) || hold_busy, 7'b0000000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_data = d;
        push     = 1'b1;
        tick();
        push     = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        phase   = P_IDLE;
        m_ticks = 0;
        m_din   = 8'h00;
        m_hval  = 8'h00;
        m_a0    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the model: pair progress, then FIFO bookkeeping
    task automatic model_edge();
        int pre;
        logic [15:0] h;
        pre = mq.size();
        case (phase)
            P_IDLE: if (pre > 0) begin
                h      = mq.pop_front();
                m_din  = h[15:8];
                m_hval = h[7:0];
                m_a0   = 1'b0;
                phase  = P_ADDR;
            end
            P_ADDR: if (cen) phase = P_GAP;
            P_GAP: if (cen) begin
                phase = P_DATA;
                m_a0  = 1'b1;
                m_din = m_hval;
            end
            P_DATA: if (cen) begin
                phase   = P_BSET;
                m_ticks = 0;
            end
            P_BSET: begin
                if (jt_dout[7]) phase = P_BCLR;
                else if (cen) begin
                    m_ticks++;
                    if (m_ticks == BUSY_TO) phase = P_IDLE;
                end
            end
            P_BCLR: if (!jt_dout[7]) phase = P_IDLE;
            default: phase = P_IDLE;
        endcase
        if (push && pre < DEPTH) mq.push_back({reg_addr, reg_data});
        if (push && pre >= DEPTH) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    // Model thread
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // cen generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (cen_mode)
                0: cen = 1'b1;
                1: begin cen_ph = !cen_ph; cen = cen_ph; end
                default: cen = ($urandom % 3) != 0;
            endcase
        end
    end

    // Per-cycle compare against the model
    initial begin
        bit strobe;
        bit m_idle;
        forever begin
            @(negedge clk);
            strobe = (phase == P_ADDR) || (phase == P_DATA);
            m_idle = (mq.size() == 0) && (phase == P_IDLE);
            chk("cs_n",  32'(jt_cs_n), 32'(!strobe));
            chk("wr_n",  32'(jt_wr_n), 32'(!strobe));
            chk("a0",    32'(jt_a0),   32'(m_a0));
            chk("din",   32'(jt_din),  32'(m_din));
            chk("level", 32'(level),   32'(mq.size()));
            chk("full",  32'(full),    32'(mq.size() == DEPTH));
            chk("empty", 32'(empty),   32'(mq.size() == 0));
            chk("ovf",   32'(ovf),     32'(m_ovf));
            chk("idle",  32'(idle),    32'(m_idle));
        end
    end

    // Bus monitor: logs completed writes, one cen per strobe window
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win_cen  = 0;
                win_open = 1'b0;
            end else if (!jt_cs_n || !jt_wr_n) begin
                win_open = 1'b1;
                if (cen) begin
                    win_cen++;
                    if (!jt_a0) last_addr = jt_din;
                    else wlog.push_back({last_addr, jt_din});
                end
            end else if (win_open) begin
                chk("strobe_cen_count", 32'(win_cen), 32'd1);
                win_cen  = 0;
                win_open = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus and directed checks
    initial begin
        logic [15:0] ovl [17];
        logic [15:0] got;
        logic [15:0] v;
        bit found;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  32'(jt_cs_n), 32'd1);
        chk("rst_wr_n",  32'(jt_wr_n), 32'd1);
        chk("rst_a0",    32'(jt_a0),   32'd0);
        chk("rst_din",   32'(jt_din),  32'd0);
        chk("rst_level", 32'(level),   32'd0);
        chk("rst_empty", 32'(empty),   32'd1);
        chk("rst_full",  32'(full),    32'd0);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chk("rst_idle",  32'(idle),    32'd1);
        #2 rst_n = 1'b1;
        tick();
        tick();

        // ---------------- single pair, busy 32 clk ----------------
        cen_mode = 0;
        busy_len = 32;
        tick();
        push_pair(8'h08, 8'h78);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 2) begin
                chk("t1_awr_cs", 32'(jt_cs_n), 32'd0);
                chk("t1_awr_a0", 32'(jt_a0),   32'd0);
                chk("t1_awr_din", 32'(jt_din), 32'h08);
            end
            if (n == 3) chk("t1_gap_cs", 32'(jt_cs_n), 32'd1);
            if (n == 4) begin
                chk("t1_dwr_cs", 32'(jt_cs_n), 32'd0);
                chk("t1_dwr_a0", 32'(jt_a0),   32'd1);
                chk("t1_dwr_din", 32'(jt_din), 32'h78);
            end
            if (n == 5) begin
                chk("t1_after_cs", 32'(jt_cs_n), 32'd1);
                chk("t1_busy_idle0", 32'(idle), 32'd0);
            end
            if (n == 37) chk("t1_idle_before_busy_fall", 32'(idle), 32'd0);
            if (n == 38) chk("t1_idle_after_busy_fall", 32'(idle), 32'd1);
        end

        // ---------------- minimum latency, busy 1 clk ----------------
        busy_len = 1;
        push_pair(8'h10, 8'h55);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 6) chk("lat_idle_n6", 32'(idle), 32'd0);
            if (n == 7) chk("lat_idle_n7", 32'(idle), 32'd1);
        end

        // ---------------- busy never asserts: timeout after 8 cen ----------------
        busy_len = 0;
        push_pair(8'h30, 8'h11);
        push_pair(8'h31, 8'h22);
        for (int n = 2; n <= 15; n++) begin
            @(negedge clk);
            if (n == 4) chk("to_dwr_din", 32'(jt_din), 32'h11);
            if (n == 13) chk("to_still_waiting", 32'(jt_cs_n), 32'd1);
            if (n == 14) begin
                chk("to_next_awr_cs", 32'(jt_cs_n), 32'd0);
                chk("to_next_awr_din", 32'(jt_din), 32'h31);
            end
        end
        repeat (20) tick();

        // ---------------- cen every 2nd clk, two pairs ----------------
        cen_mode = 1;
        busy_len = 6;
        wlog.delete();
        push_pair(8'h20, 8'hC7);
        push_pair(8'h28, 8'h4A);
        repeat (80) tick();
        chk("c2_count", 32'(wlog.size()), 32'd2);
        got = (wlog.size() > 0) ? wlog[0] : 16'hDEAD;
        chk("c2_pair0", 32'(got), 32'h20C7);
        got = (wlog.size() > 1) ? wlog[1] : 16'hDEAD;
        chk("c2_pair1", 32'(got), 32'h284A);

        // ---------------- overflow with busy held high ----------------
        cen_mode  = 0;
        busy_len  = 0;
        hold_busy = 1'b1;
        push_pair(8'hAA, 8'hBB);
        repeat (10) tick();
        for (int i = 0; i < 17; i++) begin
            v = 16'($urandom);
            ovl[i]   = v;
            reg_addr = v[15:8];
            reg_data = v[7:0];
            push     = 1'b1;
            tick();
            if (i == 15) begin
                @(negedge clk);
                chk("ovf16_level", 32'(level), 32'd16);
                chk("ovf16_full",  32'(full),  32'd1);
                chk("ovf16_ovf",   32'(ovf),   32'd0);
            end
        end
        push = 1'b0;
        @(negedge clk);
        chk("ovf17_ovf",   32'(ovf),   32'd1);
        chk("ovf17_level", 32'(level), 32'd16);
        chk("ovf17_full",  32'(full),  32'd1);
        wlog.delete();
        hold_busy = 1'b0;
        repeat (300) tick();
        chk("ovf_written_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            got = (wlog.size() > i) ? wlog[i] : 16'hDEAD;
            chk("ovf_pair_order", 32'(got), 32'(ovl[i]));
        end
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // ---------------- push and pop in the same cycle at level 3 ----------------
        hold_busy = 1'b1;
        push_pair(8'h01, 8'h01);
        repeat (10) tick();
        push_pair(8'hA1, 8'h11);
        push_pair(8'hA2, 8'h22);
        push_pair(8'hA3, 8'h33);
        tick();
        @(negedge clk);
        chk("pp_level_before", 32'(level), 32'd3);
        hold_busy = 1'b0;
        tick();
        push_pair(8'hA4, 8'h44);
        @(negedge clk);
        chk("pp_level_after", 32'(level), 32'd3);
        chk("pp_awr_cs",      32'(jt_cs_n), 32'd0);
        chk("pp_oldest_din",  32'(jt_din),  32'hA1);
        repeat (100) tick();

        // ---------------- reset in the middle of the data write ----------------
        cen_mode = 1;
        busy_len = 4;
        push_pair(8'h40, 8'h01);
        push_pair(8'h41, 8'h02);
        push_pair(8'h42, 8'h03);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!jt_cs_n && jt_a0) begin
                found = 1'b1;
                break;
            end
        end
        chk("rmid_dwr_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_cs_n",  32'(jt_cs_n), 32'd1);
        chk("rmid_wr_n",  32'(jt_wr_n), 32'd1);
        chk("rmid_level", 32'(level),   32'd0);
        chk("rmid_ovf",   32'(ovf),     32'd0);
        chk("rmid_empty", 32'(empty),   32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wlog.delete();
        cen_mode = 0;
        busy_len = 3;
        tick();
        push_pair(8'h01, 8'h02);
        repeat (40) tick();
        chk("rmid_new_count", 32'(wlog.size()), 32'd1);
        got = (wlog.size() > 0) ? wlog[0] : 16'hDEAD;
        chk("rmid_new_pair", 32'(got), 32'h0102);

        // ---------------- randomized traffic ----------------
        cen_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            push     = ($urandom % 100) < 35;
            reg_addr = 8'($urandom);
            reg_data = 8'($urandom);
            clr_ovf  = ($urandom % 100) < 4;
            busy_len = int'($urandom % 12);
            tick();
        end
        push    = 1'b0;
        clr_ovf = 1'b0;
        repeat (500) tick();
        @(negedge clk);
        chk("drained_idle", 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
